// File: rtl/ysyx_24080006_axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24080006_axi_sram_slave
//  Brief    : AXI4 responder backed by an on-chip word-addressed SRAM array.
//             One transaction at a time, FIXED/INCR/WRAP bursts up to 256
//             beats, byte strobes, ID echo, SLVERR on malformed requests.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_24080006_axi_sram_slave #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    // write address channel
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    // write data channel
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    // write response channel
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    // read address channel
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    // read data channel
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);

    localparam int         C_AW          = $clog2(MEM_WORDS);
    localparam logic [1:0] C_BURST_FIXED = 2'b00;
    localparam logic [1:0] C_BURST_WRAP  = 2'b10;
    localparam logic [1:0] C_BURST_RSVD  = 2'b11;
    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WRESP = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // storage (never reset)
    logic [31:0] r_mem [MEM_WORDS];

    // latched transaction context
    logic [31:0] r_addr;
    logic [7:0]  r_cnt;
    logic [7:0]  r_len;
    logic [1:0]  r_sz;
    logic        r_fixed;
    logic        r_wrap;
    logic [3:0]  r_id;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_last_wr;

    // handshakes and decode
    logic        w_awready;
    logic        w_arready;
    logic        w_aw_sel;
    logic        w_ar_sel;
    logic        w_w_hs;
    logic        w_r_hs;
    logic        w_cnt_last;
    logic [31:0] w_next_addr;
    logic [31:0] w_a_addr;
    logic [3:0]  w_a_id;
    logic [7:0]  w_a_len;
    logic [2:0]  w_a_size;
    logic [1:0]  w_a_burst;
    logic [1:0]  w_a_sz;
    logic        w_a_len_ok;
    logic        w_a_wrap;
    logic        w_a_err;

    // Next beat address; the wrap mask equals step*(len+1)-1 because the
    // low bits of (len << sz) are zero, so no multiplier is needed.
    function automatic logic [31:0] f_next_addr(
        input logic [31:0] addr,
        input logic [1:0]  sz,
        input logic        fixed,
        input logic        wrap,
        input logic [7:0]  len
    );
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << sz;
        mask = ({24'd0, len} << sz) | (step - 32'd1);
        if (fixed) begin
            f_next_addr = addr;
        end else if (wrap) begin
            f_next_addr = (addr & ~mask) | ((addr + step) & mask);
        end else begin
            f_next_addr = addr + step;
        end
    endfunction

    // Alternating priority: when both request, the channel not served last wins.
    assign w_aw_sel = awvalid & (~arvalid | ~r_last_wr);
    assign w_ar_sel = arvalid & (~awvalid |  r_last_wr);

    // Address-phase fields come from whichever channel is being accepted.
    assign w_a_addr  = w_awready ? awaddr  : araddr;
    assign w_a_id    = w_awready ? awid    : arid;
    assign w_a_len   = w_awready ? awlen   : arlen;
    assign w_a_size  = w_awready ? awsize  : arsize;
    assign w_a_burst = w_awready ? awburst : arburst;
    assign w_a_sz    = (w_a_size > 3'd2) ? 2'd2 : w_a_size[1:0];
    assign w_a_len_ok = (w_a_len == 8'd1) | (w_a_len == 8'd3) |
                        (w_a_len == 8'd7) | (w_a_len == 8'd15);
    assign w_a_wrap  = (w_a_burst == C_BURST_WRAP) & w_a_len_ok;
    assign w_a_err   = (w_a_size > 3'd2) | (w_a_burst == C_BURST_RSVD) |
                       ((w_a_burst == C_BURST_WRAP) & ~w_a_len_ok);

    assign w_w_hs      = (r_state == S_WDATA) & wvalid;
    assign w_r_hs      = (r_state == S_RDATA) & rready;
    assign w_cnt_last  = (r_cnt == r_len);
    assign w_next_addr = f_next_addr(r_addr, r_sz, r_fixed, r_wrap, r_len);

    // State register; reset abandons any burst immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and address-channel ready generation.
    always_comb begin
        w_state_nxt = r_state;
        w_awready   = 1'b0;
        w_arready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_awready = reset_n & w_aw_sel;
                w_arready = reset_n & w_ar_sel;
                if (w_awready) begin
                    w_state_nxt = S_WDATA;
                end else if (w_arready) begin
                    w_state_nxt = S_RDATA;
                end
            end
            S_WDATA: begin
                if (wvalid && w_cnt_last) begin
                    w_state_nxt = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RDATA: begin
                if (rready && w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transaction context, beat counter and read-data prefetch register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= 32'd0;
            r_cnt     <= 8'd0;
            r_len     <= 8'd0;
            r_sz      <= 2'd0;
            r_fixed   <= 1'b0;
            r_wrap    <= 1'b0;
            r_id      <= 4'd0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_last_wr <= 1'b0;
        end else if (w_awready || w_arready) begin
            r_addr    <= w_a_addr;
            r_cnt     <= 8'd0;
            r_len     <= w_a_len;
            r_sz      <= w_a_sz;
            r_fixed   <= (w_a_burst == C_BURST_FIXED);
            r_wrap    <= w_a_wrap;
            r_id      <= w_a_id;
            r_err     <= w_a_err;
            r_last_wr <= w_awready;
            if (w_arready) begin
                r_rdata <= r_mem[w_a_addr[C_AW+1:2]];
            end
        end else if (w_w_hs) begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= w_next_addr;
            if (wlast != w_cnt_last) begin
                r_err <= 1'b1;
            end
        end else if (w_r_hs && !w_cnt_last) begin
            r_cnt   <= r_cnt + 8'd1;
            r_addr  <= w_next_addr;
            r_rdata <= r_mem[w_next_addr[C_AW+1:2]];
        end
    end

    // Byte-lane writes into the array for each accepted W beat.
    always_ff @(posedge clock) begin
        if (w_w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    r_mem[r_addr[C_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign awready = w_awready;
    assign arready = w_arready;
    assign wready  = (r_state == S_WDATA);
    assign bvalid  = (r_state == S_WRESP);
    assign bid     = r_id;
    assign bresp   = (bvalid && r_err) ? C_RESP_SLVERR : C_RESP_OKAY;
    assign rvalid  = (r_state == S_RDATA);
    assign rid     = r_id;
    assign rdata   = r_rdata;
    assign rresp   = (rvalid && r_err) ? C_RESP_SLVERR : C_RESP_OKAY;
    assign rlast   = rvalid & w_cnt_last;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080006_axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_24080006_axi_sram_slave
//  Brief    : Directed self-checking bench for the AXI SRAM responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24080006_axi_sram_slave;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awid, arid, bid, rid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rexp [16];
    logic [15:0] rrdy_pat;

    always #5 clock = ~clock;

    ysyx_24080006_axi_sram_slave #(.MEM_WORDS(4096)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issue AW and wait for acceptance; wready must follow one cycle later.
    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int k;
        awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        #1;
        k = 0;
        while (awready !== 1'b1 && k < 20) begin
            @(posedge clock); #1; k++;
        end
        check("aw_accept", 32'(k < 20), 32'd1);
        @(posedge clock); #1;
        awvalid = 1'b0;
        check("wready_after_aw", 32'(wready), 32'd1);
    endtask

    // Send len+1 W beats from wbuf/sbuf; wlast is driven only on beat last_idx.
    task automatic w_phase(input int len, input int last_idx);
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == last_idx);
            #1;
            check("wready_beat", 32'(wready), 32'd1);
            check("bvalid_early", 32'(bvalid), 32'd0);
            @(posedge clock); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    // Expect B one cycle after the last W; optionally stall bready.
    task automatic b_phase(input logic [1:0] resp, input logic [3:0] id, input int delay);
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'(resp));
        check("bid", 32'(bid), 32'(id));
        for (int i = 0; i < delay; i++) begin
            @(posedge clock); #1;
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("bresp_hold", 32'(bresp), 32'(resp));
        end
        bready = 1'b1;
        @(posedge clock); #1;
        bready = 1'b0;
        check("bvalid_clr", 32'(bvalid), 32'd0);
    endtask

    // Issue AR; the first R beat must be valid one cycle after acceptance.
    task automatic ar_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int k;
        araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        #1;
        k = 0;
        while (arready !== 1'b1 && k < 20) begin
            @(posedge clock); #1; k++;
        end
        check("ar_accept", 32'(k < 20), 32'd1);
        @(posedge clock); #1;
        arvalid = 1'b0;
        check("rvalid_after_ar", 32'(rvalid), 32'd1);
    endtask

    // Collect beats against rexp, throttling rready by rrdy_pat; stop early at beat 'stop'.
    task automatic r_phase(input int len, input logic [3:0] id, input logic [1:0] resp, input int stop);
        int beat;
        int cyc;
        int exp_beats;
        beat = 0; cyc = 0;
        exp_beats = (stop < len + 1) ? stop : len + 1;
        while (beat <= len && beat < stop && cyc < 64) begin
            rready = (cyc < 16) ? rrdy_pat[cyc] : 1'b1;
            #1;
            check("rvalid", 32'(rvalid), 32'd1);
            check("rdata", rdata, rexp[beat]);
            check("rlast", 32'(rlast), 32'(beat == len));
            check("rid", 32'(rid), 32'(id));
            check("rresp", 32'(rresp), 32'(resp));
            if (rready) beat++;
            @(posedge clock); #1;
            cyc++;
        end
        rready = 1'b0;
        check("r_beats", 32'(beat), 32'(exp_beats));
        if (stop > len) check("rvalid_clr", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; rready = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; awid = '0; arid = '0; wstrb = '0;
        awlen = '0; arlen = '0; awsize = 3'd2; arsize = 3'd2; awburst = 2'b01; arburst = 2'b01;
        rrdy_pat = 16'hFFFF;
        repeat (3) @(posedge clock);
        #1;
        // reset state, with both requests pending
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ids", {24'd0, bid, rid}, 32'd0);
        awvalid = 1'b0; arvalid = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // single write then read
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        aw_phase(32'h10, 4'd3, 8'd0, 3'd2, 2'b01);
        w_phase(0, 0);
        b_phase(2'b00, 4'd3, 2);
        rexp[0] = 32'hDEADBEEF;
        ar_phase(32'h10, 4'd5, 8'd0, 3'd2, 2'b01);
        r_phase(0, 4'd5, 2'b00, 99);

        // byte strobes
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        aw_phase(32'h20, 4'd1, 8'd0, 3'd2, 2'b01);
        w_phase(0, 0);
        b_phase(2'b00, 4'd1, 0);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        aw_phase(32'h20, 4'd2, 8'd0, 3'd2, 2'b01);
        w_phase(0, 0);
        b_phase(2'b00, 4'd2, 0);
        rexp[0] = 32'h11BB33DD;
        ar_phase(32'h20, 4'd4, 8'd0, 3'd2, 2'b01);
        r_phase(0, 4'd4, 2'b00, 99);

        // INCR burst with rready throttling 1,0,1,1,0,1
        for (int i = 0; i < 4; i++) begin wbuf[i] = i; sbuf[i] = 4'hF; rexp[i] = i; end
        aw_phase(32'h100, 4'd6, 8'd3, 3'd2, 2'b01);
        w_phase(3, 3);
        b_phase(2'b00, 4'd6, 0);
        rrdy_pat = 16'hFFED;
        ar_phase(32'h100, 4'd7, 8'd3, 3'd2, 2'b01);
        r_phase(3, 4'd7, 2'b00, 99);
        rrdy_pat = 16'hFFFF;

        // FIXED burst holds the address
        for (int i = 0; i < 3; i++) rexp[i] = 32'd1;
        ar_phase(32'h104, 4'd8, 8'd2, 3'd2, 2'b00);
        r_phase(2, 4'd8, 2'b00, 99);

        // WRAP burst
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; end
        aw_phase(32'h200, 4'd2, 8'd3, 3'd2, 2'b01);
        w_phase(3, 3);
        b_phase(2'b00, 4'd2, 0);
        rexp[0] = 32'hA2; rexp[1] = 32'hA3; rexp[2] = 32'hA0; rexp[3] = 32'hA1;
        ar_phase(32'h208, 4'd3, 8'd3, 3'd2, 2'b10);
        r_phase(3, 4'd3, 2'b00, 99);

        // arbitration: last served was a read, so write wins first
        araddr = 32'h300; arid = 4'd9; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        awaddr = 32'h300; awid = 4'd8; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        #1;
        check("arb1_awready", 32'(awready), 32'd1);
        check("arb1_arready", 32'(arready), 32'd0);
        wbuf[0] = 32'h55; sbuf[0] = 4'hF;
        aw_phase(32'h300, 4'd8, 8'd0, 3'd2, 2'b01);
        w_phase(0, 0);
        b_phase(2'b00, 4'd8, 0);
        awaddr = 32'h304; awid = 4'd10; awvalid = 1'b1;
        #1;
        check("arb2_arready", 32'(arready), 32'd1);
        check("arb2_awready", 32'(awready), 32'd0);
        rexp[0] = 32'h55;
        ar_phase(32'h300, 4'd9, 8'd0, 3'd2, 2'b01);
        check("aw_blocked_in_read", 32'(awready), 32'd0);
        r_phase(0, 4'd9, 2'b00, 99);
        wbuf[0] = 32'h66;
        aw_phase(32'h304, 4'd10, 8'd0, 3'd2, 2'b01);
        w_phase(0, 0);
        b_phase(2'b00, 4'd10, 0);
        rexp[0] = 32'h66;
        ar_phase(32'h304, 4'd1, 8'd0, 3'd2, 2'b01);
        r_phase(0, 4'd1, 2'b00, 99);

        // early wlast: still four beats, SLVERR, data written anyway
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h40 + i; sbuf[i] = 4'hF; rexp[i] = 32'h40 + i; end
        aw_phase(32'h400, 4'd11, 8'd3, 3'd2, 2'b01);
        w_phase(3, 1);
        b_phase(2'b10, 4'd11, 0);
        ar_phase(32'h400, 4'd12, 8'd3, 3'd2, 2'b01);
        r_phase(3, 4'd12, 2'b00, 99);

        // oversize read: SLVERR but full word returned
        rexp[0] = 32'hDEADBEEF;
        ar_phase(32'h10, 4'd12, 8'd0, 3'd3, 2'b01);
        r_phase(0, 4'd12, 2'b10, 99);

        // asynchronous reset on beat 2 of a len-7 read
        rexp[0] = 32'd0; rexp[1] = 32'd1;
        ar_phase(32'h100, 4'd13, 8'd7, 3'd2, 2'b01);
        r_phase(7, 4'd13, 2'b00, 2);
        check("rvalid_beat2", 32'(rvalid), 32'd1);
        awvalid = 1'b1; arvalid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rvalid", 32'(rvalid), 32'd0);
        check("async_awready", 32'(awready), 32'd0);
        check("async_arready", 32'(arready), 32'd0);
        check("async_rlast", 32'(rlast), 32'd0);
        awvalid = 1'b0; arvalid = 1'b0;
        @(posedge clock); #3;
        reset_n = 1'b1;
        @(posedge clock); #1;
        rexp[0] = 32'hDEADBEEF;
        ar_phase(32'h10, 4'd14, 8'd0, 3'd2, 2'b01);
        r_phase(0, 4'd14, 2'b00, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_24080006_axi_sram_slave.md
# ysyx_24080006_axi_sram_slave

AXI4 responder (slave) backed by an on-chip word-addressed SRAM array; it answers the read and write channels that the core-side interconnect drives as an initiator. It attaches to the SoC `io_slave_*` port, and serves as a standalone memory model for NPC-mode simulation. It handles one transaction at a time, supports FIXED/INCR/WRAP bursts of up to 256 beats and byte strobes, and echoes the transaction ID.

## Interface
- `MEM_WORDS`, 4096: number of 32-bit words in the array; a power of two.
- `clock` in 1: single clock; everything is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `awvalid/awready` in/out 1; `awaddr` in 32; `awid` in 4; `awlen` in 8; `awsize` in 3; `awburst` in 2.
- `wvalid/wready` in/out 1; `wdata` in 32; `wstrb` in 4; `wlast` in 1.
- `bvalid` out 1; `bready` in 1; `bresp` out 2; `bid` out 4.
- `arvalid/arready` in/out 1; `araddr` in 32; `arid` in 4; `arlen` in 8; `arsize` in 3; `arburst` in 2.
- `rvalid` out 1; `rready` in 1; `rdata` out 32; `rresp` out 2; `rlast` out 1; `rid` out 4.

## Operation
- States:
  - IDLE, WDATA, WRESP, RDATA.
  - Reset enters IDLE with write priority.
  - Every output resets to 0.
- **Arbitration in IDLE:**
  - `awready` = IDLE & awvalid-eligible; `arready` = IDLE & arvalid-eligible.
  - If only one channel is valid, it wins.
  - If both are valid, the channel that was *not* served last wins (alternating priority).
  - `awready` and `arready` are never both 1.
- **Address handshake:**
  - Latch id, len, size, burst and the start address.
  - Clear the beat counter.
  - Set the error flag if `size > 2` or `burst == 2'b11`.
- **Beat address:**
  - Word index = `addr[log2(MEM_WORDS)+1:2]`; the address aliases modulo the array size.
  - Step = `1 << min(size,2)`.
  - FIXED (00): address held for all beats.
  - INCR (01), or reserved 11: address += step. Bit 31 wraps mod 2^32.
  - WRAP (10): wrap window = step*(len+1). `next = (addr & ~(win-1)) | ((addr+step) & (win-1))`.
  - WRAP with `len` not in {1,3,7,15} sets the error flag and behaves as INCR.
- **Write (WDATA):**
  - `wready` = 1.
  - Each `wvalid&wready` writes byte lanes where `wstrb[i]` = 1 and advances the counter.
  - `wlast` must equal (count == len). A mismatch on any beat sets the error flag.
  - The slave still consumes exactly `len+1` beats, then goes to WRESP.
- **WRESP:**
  - `bvalid` = 1, `bid` = latched id, `bresp` = error ? 2'b10 (SLVERR) : 2'b00.
  - Held stable until `bready`, then return to IDLE.
- **Read (RDATA):**
  - `rvalid` = 1, `rid` = latched id, `rresp` per error flag.
  - `rlast` = (count == len).
  - `rdata` = full 32-bit word at the beat address; narrow reads return the full word.
  - Each `rvalid&rready` advances; after the last beat, return to IDLE.
- Errored transactions still read and write the array normally; only the response code differs.

## Timing
- **Write path:**
  - AW handshake at cycle T → `wready` = 1 from T+1.
  - The last W beat accepted at cycle U → `bvalid` = 1 at U+1.
  - After the B handshake, `awready`/`arready` may assert the next cycle.
- **Read path:**
  - AR handshake at T → first beat has `rvalid` = 1 at T+1.
  - Subsequent beats sustain 1 beat/cycle while `rready` = 1. `rdata` is registered and prefetched so no bubble is allowed.
- **Backpressure:** while `rvalid&~rready` or `bvalid&~bready`, every R/B output is held bit-stable.
- **Read-after-write:**
  - A write committed on cycle U is visible to any read beat issued after U.
  - The last W beat precedes `bvalid`, so reads issued after B always see new data.
- **Reset:**
  - `reset_n` low mid-burst forces IDLE immediately and drops all valid/ready outputs asynchronously.
  - Array contents are not reset.
  - An in-flight burst is abandoned.
- `wvalid` while in IDLE or RDATA is ignored (`wready` = 0); no W data is accepted before AW.

## Test plan
- **Single write then read:**
  - AW addr 0x10, len 0, size 2, wdata 0xDEADBEEF, wstrb 0xF, awid 3 → `bvalid` one cycle after W, bresp 00, bid 3.
  - AR 0x10, arid 5 → rdata 0xDEADBEEF, rlast 1, rid 5, rvalid one cycle after AR.
- **Byte strobes:**
  - Write 0x11223344 to 0x20.
  - Then write 0xAABBCCDD with wstrb 0b0101.
  - Read 0x20 → 0x11BB33DD.
- **INCR burst with rready throttling:**
  - Write 4 beats 0..3 at 0x100.
  - Read len 3 with rready toggled 1,0,1,1,0,1 → data 0,1,2,3 in order, rlast only on beat 3, outputs stable during stalls.
- **WRAP burst:**
  - Preload words 0x200..0x20C with 0xA0..0xA3.
  - AR 0x208, len 3, WRAP → rdata sequence 0xA2, 0xA3, 0xA0, 0xA1.
- **Errors and arbitration:**
  - Early `wlast` on beat 1 of a len-3 write → 4 beats still consumed, bresp 2'b10.
  - awvalid and arvalid asserted together twice in a row → write served first, read second.
- **Async reset mid-read burst:**
  - Pull `reset_n` low on beat 2 of a len-7 read → rvalid/arready/awready drop to 0 without a clock edge.
  - After release, a new AR is accepted normally.
